// File: rtl/awg_pkg.sv
// Shared types and constants for the AWG configuration controller.
// Holds FSM encoding, default parameters and reset-time DDS settings.
package awg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WAIT_WRAP,
    COMMIT
  } state_t;

  localparam logic [31:0] FTW_STEP_DEF     = 32'd42950;
  localparam logic [15:0] WRAP_TIMEOUT_DEF = 16'd50000;
  localparam logic [4:0]  WAVE_MAX         = 5'd4;
  localparam logic [3:0]  MULT_CYCLES      = 4'd8;

  localparam logic [4:0]  RST_WAVE  = 5'd3;
  localparam logic [7:0]  RST_AMP   = 8'd1;
  localparam logic [31:0] RST_PHASE = 32'h0100_0000;

  function automatic logic cfg_ok(
    input logic [4:0] wave,
    input logic [7:0] freq,
    input logic [7:0] amp
  );
    return (wave <= WAVE_MAX) &&
           (freq != 8'd0) &&
           (amp != 8'd0);
  endfunction

endpackage

// File: rtl/ftw_mult.sv
// Serial shift-add multiplier: 8-bit x 32-bit, 32-bit truncated product.
// One multiplier bit per cycle; done is high during the eighth step.
module ftw_mult
  import awg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_prod
);

  logic [7:0]  r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;
  logic        r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_a[0])
        r_acc <= r_acc + r_b;
      r_a   <= r_a >> 1;
      r_b   <= r_b << 1;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == MULT_CYCLES - 4'd1)
        r_run <= 1'b0;
    end
  end

  assign o_done = r_run &&
                  (r_cnt == MULT_CYCLES - 4'd1);
  assign o_prod = r_acc;

endmodule

// File: rtl/awg_cfg_ctrl.sv
// DDS configuration controller: accepts a parameter set, computes the
// tuning word serially, then commits all outputs on an accumulator wrap.
module awg_cfg_ctrl
  import awg_pkg::*;
#(
  parameter logic [31:0] FTW_STEP     = FTW_STEP_DEF,
  parameter logic [15:0] WRAP_TIMEOUT = WRAP_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [4:0]  cfg_wave,
  input  logic [7:0]  cfg_freq,
  input  logic [7:0]  cfg_amp,
  input  logic [7:0]  cfg_phase,
  input  logic        acc_wrap,
  output logic [31:0] ftw,
  output logic [31:0] phase_off,
  output logic [7:0]  amp_scale,
  output logic [4:0]  wave_sel,
  output logic        upd_strobe,
  output logic        busy,
  output logic        cfg_err
);

  state_t r_state;
  state_t w_next;

  logic [4:0]  r_wave;
  logic [7:0]  r_amp;
  logic [7:0]  r_phase;
  logic [15:0] r_wcnt;
  logic [31:0] r_ftw;
  logic [31:0] r_phase_off;
  logic [7:0]  r_amp_scale;
  logic [4:0]  r_wave_sel;
  logic        r_err;

  logic        w_xfer;
  logic        w_ok;
  logic        w_start;
  logic        w_done;
  logic        w_go;
  logic [31:0] w_prod;

  assign w_xfer  = cfg_valid && (r_state == IDLE);
  assign w_ok    = cfg_ok(cfg_wave, cfg_freq, cfg_amp);
  assign w_start = w_xfer && w_ok;
  // Wrap pulse and timeout landing together still give one commit.
  assign w_go    = acc_wrap ||
                   (r_wcnt == WRAP_TIMEOUT - 16'd1);

  ftw_mult u_mult (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_a     (cfg_freq),
    .i_b     (FTW_STEP),
    .o_done  (w_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_start) w_next = CALC;
      CALC:      if (w_done)  w_next = WAIT_WRAP;
      WAIT_WRAP: if (w_go)    w_next = COMMIT;
      COMMIT:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wave      <= '0;
      r_amp       <= '0;
      r_phase     <= '0;
      r_wcnt      <= '0;
      r_err       <= 1'b0;
      r_ftw       <= FTW_STEP;
      r_phase_off <= RST_PHASE;
      r_amp_scale <= RST_AMP;
      r_wave_sel  <= RST_WAVE;
    end else begin
      if (w_xfer)
        r_err <= !w_ok;
      if (w_start) begin
        r_wave  <= cfg_wave;
        r_amp   <= cfg_amp;
        r_phase <= cfg_phase;
      end
      if (r_state == WAIT_WRAP)
        r_wcnt <= r_wcnt + 16'd1;
      else
        r_wcnt <= '0;
      // Load on entry so the new set is visible with the strobe.
      if (r_state == WAIT_WRAP && w_go) begin
        r_ftw       <= w_prod;
        r_phase_off <= {r_phase, 24'd0};
        r_amp_scale <= r_amp;
        r_wave_sel  <= r_wave;
      end
    end
  end

  assign cfg_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign upd_strobe = (r_state == COMMIT);
  assign cfg_err    = r_err;
  assign ftw        = r_ftw;
  assign phase_off  = r_phase_off;
  assign amp_scale  = r_amp_scale;
  assign wave_sel   = r_wave_sel;

endmodule

// File: tb/tb_awg_cfg_ctrl.sv
// Scoreboard bench for awg_cfg_ctrl with a behavioural reference model.
// Stimulus pushes expected commits; a monitor pops them on upd_strobe.
module tb_awg_cfg_ctrl;

  localparam logic [31:0] STEP = 32'd42950;
  localparam int          TO   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [4:0]  cfg_wave = '0;
  logic [7:0]  cfg_freq = '0;
  logic [7:0]  cfg_amp = '0;
  logic [7:0]  cfg_phase = '0;
  logic        acc_wrap = 1'b0;
  logic [31:0] ftw;
  logic [31:0] phase_off;
  logic [7:0]  amp_scale;
  logic [4:0]  wave_sel;
  logic        upd_strobe;
  logic        busy;
  logic        cfg_err;

  awg_cfg_ctrl #(
    .FTW_STEP     (STEP),
    .WRAP_TIMEOUT (16'(TO))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_wave   (cfg_wave),
    .cfg_freq   (cfg_freq),
    .cfg_amp    (cfg_amp),
    .cfg_phase  (cfg_phase),
    .acc_wrap   (acc_wrap),
    .ftw        (ftw),
    .phase_off  (phase_off),
    .amp_scale  (amp_scale),
    .wave_sel   (wave_sel),
    .upd_strobe (upd_strobe),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ftw;
    logic [31:0] ph;
    logic [7:0]  amp;
    logic [4:0]  wave;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // Monitor: strobes pop the scoreboard, otherwise outputs must hold.
  logic [31:0] p_ftw, p_ph;
  logic [7:0]  p_amp;
  logic [4:0]  p_wave;
  always @(negedge clk) begin
    if (!rst) begin
      if (upd_strobe) begin
        if (q.size() == 0) begin
          chk("extra_strobe", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ftw", 64'(ftw), 64'(e.ftw));
          chk("phase_off", 64'(phase_off), 64'(e.ph));
          chk("amp_scale", 64'(amp_scale), 64'(e.amp));
          chk("wave_sel", 64'(wave_sel), 64'(e.wave));
          chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("hold_outputs",
            {ftw, phase_off},
            {p_ftw, p_ph});
        chk("hold_amp_wave",
            64'({amp_scale, wave_sel}),
            64'({p_amp, p_wave}));
      end
    end
    p_ftw  = ftw;
    p_ph   = phase_off;
    p_amp  = amp_scale;
    p_wave = wave_sel;
  end

  // Called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic send(input logic [4:0] w, input logic [7:0] f,
                      input logic [7:0] a, input logic [7:0] p,
                      input int d, input bit hold, input bit spur);
    int          tx;
    int          wn;
    bit          ok;
    logic [63:0] prod;
    exp_t        e;
    ok = (w <= 5'd4) && (f != 0) && (a != 0);
    chk("ready_idle", 64'(cfg_ready), 64'd1);
    cfg_wave  = w;
    cfg_freq  = f;
    cfg_amp   = a;
    cfg_phase = p;
    cfg_valid = 1'b1;
    acc_wrap  = 1'b0;
    tx = cyc;
    if (!ok) begin
      @(negedge clk);
      chk("err_set", 64'(cfg_err), 64'd1);
      chk("reject_idle", 64'(busy), 64'd0);
      cfg_valid = 1'b0;
      return;
    end
    wn   = (d > TO) ? TO : d;
    prod = 64'(f) * 64'(STEP);
    e.ftw  = prod[31:0];
    e.ph   = 32'(p) * 32'h0100_0000;
    e.amp  = a;
    e.wave = w;
    e.cyc  = tx + 9 + wn;
    q.push_back(e);
    for (int n = 1; n <= 9 + wn; n++) begin
      @(negedge clk);
      if (hold) begin
        cfg_wave  = 5'($urandom);
        cfg_freq  = 8'($urandom);
        cfg_amp   = 8'($urandom);
        cfg_phase = 8'($urandom);
      end else begin
        cfg_valid = 1'b0;
      end
      acc_wrap = (d <= TO && n == 8 + d) || (spur && n == 3);
      if (n == 1)
        chk("err_clear", 64'(cfg_err), 64'd0);
      chk("busy", 64'(busy), 64'd1);
      chk("not_ready", 64'(cfg_ready), 64'd0);
    end
    @(negedge clk);
    acc_wrap = 1'b0;
    chk("back_ready", 64'(cfg_ready), 64'd1);
    chk("back_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    bit   prev_hold;
    bit   hold;
    bit   ok;
    logic [4:0] w;
    logic [7:0] f, a, p;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_wave", 64'(wave_sel), 64'd3);
    chk("rst_ftw", 64'(ftw), 64'd42950);
    chk("rst_amp", 64'(amp_scale), 64'd1);
    chk("rst_phase", 64'(phase_off), 64'h0100_0000);
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    chk("rst_busy_err", 64'({busy, cfg_err, upd_strobe}), 64'd0);

    send(5'd2, 8'd10, 8'd5, 8'd128, 3, 1'b0, 1'b1);
    chk("ex_ftw", 64'(ftw), 64'd429500);
    chk("ex_phase", 64'(phase_off), 64'h8000_0000);

    send(5'd1, 8'd0, 8'd9, 8'd9, 1, 1'b0, 1'b0);
    send(5'd7, 8'd4, 8'd9, 8'd9, 1, 1'b0, 1'b0);
    send(5'd0, 8'd4, 8'd0, 8'd9, 1, 1'b0, 1'b0);
    chk("rej_ftw", 64'(ftw), 64'd429500);
    chk("rej_wave", 64'(wave_sel), 64'd2);

    send(5'd0, 8'd3, 8'd7, 8'd1, 25, 1'b0, 1'b0);
    send(5'd4, 8'd200, 8'd255, 8'd255, 20, 1'b0, 1'b0);
    send(5'd4, 8'd200, 8'd255, 8'd255, 5, 1'b0, 1'b1);
    send(5'd1, 8'd7, 8'd3, 8'd64, 2, 1'b1, 1'b0);
    send(5'd3, 8'd9, 8'd9, 8'd9, 4, 1'b0, 1'b0);

    // Reset during CALC: defaults at once and no commit afterwards.
    cfg_wave  = 5'd1;
    cfg_freq  = 8'd77;
    cfg_amp   = 8'd66;
    cfg_phase = 8'd55;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ftw", 64'(ftw), 64'd42950);
    chk("mid_rst_phase", 64'(phase_off), 64'h0100_0000);
    chk("mid_rst_aw", 64'({amp_scale, wave_sel}),
        64'({8'd1, 5'd3}));
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc_wrap = 1'($urandom);
    end
    acc_wrap = 1'b0;
    chk("post_rst_idle", 64'(busy), 64'd0);

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!prev_hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          acc_wrap = 1'($urandom);
        end
      end
      w = 5'($urandom_range(0, 6));
      f = ($urandom_range(0, 7) == 0) ? 8'd0
                                      : 8'($urandom_range(1, 255));
      a = ($urandom_range(0, 7) == 0) ? 8'd0
                                      : 8'($urandom_range(1, 255));
      p = 8'($urandom);
      hold = (i != 39) && ($urandom_range(0, 3) == 0);
      ok = (w <= 5'd4) && (f != 0) && (a != 0);
      send(w, f, a, p, int'($urandom_range(1, 25)), hold,
           1'($urandom));
      prev_hold = hold && ok;
    end
    cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
